// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel datapath.
// Holds the move-direction encoding (shared with the scan controller),
// the pixel-fetch state and mode encodings, the pixel width, and small
// helpers used by the fetch stage.
package sobel_pkg;

    localparam int unsigned SOBEL_PIX_W = 8;

    // Move direction reported by the scan controller.
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    // Pixel-fetch controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FULL = 2'b01,
        ST_PART = 2'b10,
        ST_DONE = 2'b11
    } fetch_state_e;

    // Which pixels the current fetch targets.
    typedef enum logic [1:0] {
        MODE_FULL  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_DOWN  = 2'b11
    } fetch_mode_e;

    // Map a non-zero move direction onto the partial-fetch mode.
    function automatic fetch_mode_e dir_to_mode(input logic [1:0] dir);
        fetch_mode_e mode;
        case (dir)
            DIR_RIGHT: mode = MODE_RIGHT;
            DIR_LEFT:  mode = MODE_LEFT;
            DIR_DOWN:  mode = MODE_DOWN;
            default:   mode = MODE_FULL;
        endcase
        return mode;
    endfunction

    // Index of the final read of a fetch in the given mode.
    function automatic logic [3:0] last_index(input fetch_mode_e mode);
        logic [3:0] idx;
        if (mode == MODE_FULL) begin
            idx = 4'd8;
        end else begin
            idx = 4'd2;
        end
        return idx;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational address/slot generator for the window fetch.
// Maps the window centre address, row stride, fetch mode and read index
// to the SRAM address of that read and the window slot (r*3+c) it fills.
// Ports:
//   addr_r   in  centre pixel address
//   length   in  row stride (truncated to ADDR_W bits)
//   mode     in  fetch mode (full / right / left / down)
//   idx      in  read index within the fetch
//   mem_addr out SRAM address, modulo 2^ADDR_W
//   slot     out target window slot
module window_addr_gen
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic [ADDR_W-1:0] addr_r,
    input  logic [LEN_W-1:0]  length,
    input  fetch_mode_e       mode,
    input  logic [3:0]        idx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        slot
);

    logic [1:0]        row_s;
    logic [1:0]        col_s;
    logic [ADDR_W-1:0] len_s;
    logic [ADDR_W-1:0] row_off_s;
    logic [ADDR_W-1:0] col_off_s;

    // Only the low ADDR_W bits of the stride take part in address arithmetic.
    assign len_s = length[ADDR_W-1:0];

    if (LEN_W > ADDR_W) begin : g_len_hi
        logic unused_len_hi_s;
        assign unused_len_hi_s = ^length[LEN_W-1:ADDR_W];
    end

    // Decode the read index into the (row, column) of the pixel being fetched.
    always_comb begin
        row_s = 2'd0;
        col_s = 2'd0;
        case (mode)
            MODE_FULL: begin
                case (idx)
                    4'd0:    begin row_s = 2'd0; col_s = 2'd0; end
                    4'd1:    begin row_s = 2'd0; col_s = 2'd1; end
                    4'd2:    begin row_s = 2'd0; col_s = 2'd2; end
                    4'd3:    begin row_s = 2'd1; col_s = 2'd0; end
                    4'd4:    begin row_s = 2'd1; col_s = 2'd1; end
                    4'd5:    begin row_s = 2'd1; col_s = 2'd2; end
                    4'd6:    begin row_s = 2'd2; col_s = 2'd0; end
                    4'd7:    begin row_s = 2'd2; col_s = 2'd1; end
                    4'd8:    begin row_s = 2'd2; col_s = 2'd2; end
                    default: begin row_s = 2'd0; col_s = 2'd0; end
                endcase
            end
            MODE_RIGHT: begin row_s = idx[1:0]; col_s = 2'd2; end
            MODE_LEFT:  begin row_s = idx[1:0]; col_s = 2'd0; end
            MODE_DOWN:  begin row_s = 2'd2;     col_s = idx[1:0]; end
            default:    begin row_s = 2'd0;     col_s = 2'd0; end
        endcase
    end

    // Row/column offsets relative to the centre; negative values wrap silently.
    always_comb begin
        case (row_s)
            2'd0:    row_off_s = {ADDR_W{1'b0}} - len_s;
            2'd1:    row_off_s = {ADDR_W{1'b0}};
            2'd2:    row_off_s = len_s;
            default: row_off_s = {ADDR_W{1'b0}};
        endcase
        case (col_s)
            2'd0:    col_off_s = {ADDR_W{1'b1}};
            2'd1:    col_off_s = {ADDR_W{1'b0}};
            2'd2:    col_off_s = {{(ADDR_W-1){1'b0}}, 1'b1};
            default: col_off_s = {ADDR_W{1'b0}};
        endcase
    end

    assign mem_addr = addr_r + row_off_s + col_off_s;
    assign slot     = ({2'b00, row_s} * 4'd3) + {2'b00, col_s};

endmodule

// File: rtl/window_fetch.sv
// Pixel-fetch stage of the Sobel datapath.
// On an initial load it reads all nine pixels of the 3x3 window from image
// SRAM; on a move it shifts the window and reads the one new column or row.
// The completed window is presented to the gradient stage with a valid flag.
// Ports:
//   clk, n_reset       clock, asynchronous active-low reset
//   length             image row stride
//   addr_r, direction  window centre and last move, from the scan controller
//   load_initial       pulse: start of a new image (full fetch)
//   move_done          pulse: window moved one step (partial fetch)
//   mem_read/mem_addr  SRAM read request and address
//   mem_rdata/rvalid   SRAM read data; a read completes on mem_read && mem_rvalid
//   window             9 pixels, slot r*3+c, slot 0 in the LSBs
//   window_valid       window complete and stable
//   window_done        one-cycle pulse when a fetch finishes
//   overrun            sticky: a request arrived while busy
module window_fetch
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = SOBEL_PIX_W,
    parameter int LEN_W  = 12
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [LEN_W-1:0]     length,
    input  logic [ADDR_W-1:0]    addr_r,
    input  logic [1:0]           direction,
    input  logic                 load_initial,
    input  logic                 move_done,
    output logic                 mem_read,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [PIX_W-1:0]     mem_rdata,
    input  logic                 mem_rvalid,
    output logic [9*PIX_W-1:0]   window,
    output logic                 window_valid,
    output logic                 window_done,
    output logic                 overrun
);

    fetch_state_e      state_q, state_d;
    fetch_mode_e       mode_q, mode_d;
    logic [3:0]        idx_q, idx_d;
    logic [PIX_W-1:0]  win_q [9];
    logic [PIX_W-1:0]  win_d [9];
    logic              mem_read_q, mem_read_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic              req_any_s;
    logic              move_ok_s;
    logic              completion_s;
    logic              last_s;
    logic [ADDR_W-1:0] gen_addr_s;
    logic [3:0]        slot_s;

    assign req_any_s    = load_initial | move_done;
    assign move_ok_s    = move_done & (direction != DIR_NONE);
    assign completion_s = mem_read_q & mem_rvalid;
    assign last_s       = (idx_q == last_index(mode_q));

    window_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .addr_r   (addr_r),
        .length   (length),
        .mode     (mode_q),
        .idx      (idx_q),
        .mem_addr (gen_addr_s),
        .slot     (slot_s)
    );

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_initial takes priority over move_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_initial) begin
                    state_d = ST_FULL;
                end else if (move_ok_s) begin
                    state_d = ST_PART;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL, ST_PART: begin
                if (completion_s && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: window shift, read tracking, flags.
    always_comb begin
        win_d      = win_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        mem_read_d = mem_read_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (load_initial) begin
                    mode_d     = MODE_FULL;
                    idx_d      = 4'd0;
                    mem_read_d = 1'b1;
                    valid_d    = 1'b0;
                    overrun_d  = 1'b0;
                end else if (move_ok_s) begin
                    mode_d     = dir_to_mode(direction);
                    idx_d      = 4'd0;
                    mem_read_d = 1'b1;
                    valid_d    = 1'b0;
                    // Existing pixels slide on the accepting edge; the vacated
                    // column/row is refilled by the reads that follow.
                    case (direction)
                        DIR_RIGHT: begin
                            for (int r = 0; r < 3; r++) begin
                                win_d[r*3]   = win_q[r*3+1];
                                win_d[r*3+1] = win_q[r*3+2];
                            end
                        end
                        DIR_LEFT: begin
                            for (int r = 0; r < 3; r++) begin
                                win_d[r*3+2] = win_q[r*3+1];
                                win_d[r*3+1] = win_q[r*3];
                            end
                        end
                        DIR_DOWN: begin
                            for (int c = 0; c < 3; c++) begin
                                win_d[c]   = win_q[3+c];
                                win_d[3+c] = win_q[6+c];
                            end
                        end
                        default: win_d = win_q;
                    endcase
                end else begin
                    mode_d = mode_q;
                end
            end
            ST_FULL, ST_PART: begin
                if (req_any_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (completion_s) begin
                    if (slot_s <= 4'd8) begin
                        win_d[slot_s] = mem_rdata;
                    end else begin
                        win_d = win_q;
                    end
                    idx_d = idx_q + 4'd1;
                    if (last_s) begin
                        mem_read_d = 1'b0;
                        valid_d    = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        mem_read_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DONE: begin
                if (req_any_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: begin
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mode_q     <= MODE_FULL;
            idx_q      <= 4'd0;
            mem_read_q <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= {PIX_W{1'b0}};
            end
        end else begin
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            mem_read_q <= mem_read_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // addr_r only becomes valid the cycle after a request, so the address is
    // formed from the live centre and the registered index; it is forced to
    // zero whenever no read is outstanding.
    assign mem_addr     = mem_read_q ? gen_addr_s : {ADDR_W{1'b0}};
    assign mem_read     = mem_read_q;
    assign window_valid = valid_q;
    assign window_done  = done_q;
    assign overrun      = overrun_q;

    for (genvar g = 0; g < 9; g++) begin : g_pack
        assign window[g*PIX_W +: PIX_W] = win_q[g];
    end

endmodule

// File: tb/tb_window_fetch.sv
module tb_window_fetch;

    logic        clk;
    logic        n_reset;
    logic [11:0] length;
    logic [7:0]  addr_r;
    logic [1:0]  direction;
    logic        load_initial;
    logic        move_done;
    logic        mem_read;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [71:0] window;
    logic        window_valid;
    logic        window_done;
    logic        overrun;

    window_fetch #(.ADDR_W(8), .PIX_W(8), .LEN_W(12)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .length       (length),
        .addr_r       (addr_r),
        .direction    (direction),
        .load_initial (load_initial),
        .move_done    (move_done),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .window       (window),
        .window_valid (window_valid),
        .window_done  (window_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int req_cyc  = 0;
    int wait_cfg = 0;

    logic [7:0]  exp_addr_q [$];
    logic [71:0] exp_win_q  [$];

    logic [7:0] served;
    bit         cur_active;
    int         wcnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] w9(input int p0, input int p1, input int p2,
                                       input int p3, input int p4, input int p5,
                                       input int p6, input int p7, input int p8);
        return {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0],
                p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endfunction

    task automatic push3(input int a, input int b, input int c);
        exp_addr_q.push_back(a[7:0]);
        exp_addr_q.push_back(b[7:0]);
        exp_addr_q.push_back(c[7:0]);
    endtask

    // Memory model (data = address, wait_cfg wait cycles) plus read-address monitor.
    initial begin
        cur_active = 1'b0;
        wcnt       = 0;
        served     = 8'd0;
    end

    always @(negedge clk) begin
        if (mem_rvalid && n_reset) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_unexpected actual=%0d required=none", served);
            end else begin
                chk("read_addr", {64'd0, served}, {64'd0, exp_addr_q.pop_front()});
            end
        end
        if (mem_read && n_reset) begin
            if (!cur_active) begin
                served     = mem_addr;
                cur_active = 1'b1;
                wcnt       = 0;
            end else begin
                chk("addr_stable", {64'd0, mem_addr}, {64'd0, served});
            end
            if (wcnt >= wait_cfg) begin
                mem_rvalid = 1'b1;
                mem_rdata  = served;
                cur_active = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                wcnt++;
            end
        end else begin
            mem_rvalid = 1'b0;
            cur_active = 1'b0;
        end
    end

    // Window monitor: every window_done pops one expected window.
    always @(negedge clk) begin
        if (n_reset && window_done) begin
            if (exp_win_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=%0h required=none", window);
            end else begin
                chk("window", window, exp_win_q.pop_front());
                chk("valid_at_done", {71'd0, window_valid}, 72'd1);
            end
        end
    end

    task automatic do_req(input bit ld, input bit mv, input int a, input int d);
        @(negedge clk);
        addr_r       = a[7:0];
        direction    = d[1:0];
        load_initial = ld;
        move_done    = mv;
        req_cyc      = cyc;
        @(negedge clk);
        load_initial = 1'b0;
        move_done    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            if (window_done) begin
                lat = cyc - req_cyc;
                break;
            end
            @(negedge clk);
        end
        chk(name, 72'(lat), 72'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreads;
        n_reset      = 1'b0;
        length       = 12'd10;
        addr_r       = 8'd0;
        direction    = 2'd0;
        load_initial = 1'b0;
        move_done    = 1'b0;
        mem_rdata    = 8'd0;
        mem_rvalid   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_read", {71'd0, mem_read}, 72'd0);
        chk("rst_mem_addr", {64'd0, mem_addr}, 72'd0);
        chk("rst_window", window, 72'd0);
        chk("rst_valid", {71'd0, window_valid}, 72'd0);
        chk("rst_done", {71'd0, window_done}, 72'd0);
        chk("rst_overrun", {71'd0, overrun}, 72'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // Full load around centre 11.
        push3(0, 1, 2); push3(10, 11, 12); push3(20, 21, 22);
        exp_win_q.push_back(w9(0, 1, 2, 10, 11, 12, 20, 21, 22));
        do_req(1'b1, 1'b0, 11, 0);
        chk("full_mem_read", {71'd0, mem_read}, 72'd1);
        chk("full_valid_low", {71'd0, window_valid}, 72'd0);
        wait_done("full_latency", 10);

        // Right move to centre 12.
        push3(3, 13, 23);
        exp_win_q.push_back(w9(1, 2, 3, 11, 12, 13, 21, 22, 23));
        do_req(1'b0, 1'b1, 12, 1);
        chk("right_valid_low", {71'd0, window_valid}, 72'd0);
        wait_done("right_latency", 4);

        // Down move to centre 17.
        push3(26, 27, 28);
        exp_win_q.push_back(w9(11, 12, 13, 21, 22, 23, 26, 27, 28));
        do_req(1'b0, 1'b1, 17, 3);
        wait_done("down_latency", 4);

        // Left move to centre 16.
        push3(5, 15, 25);
        exp_win_q.push_back(w9(5, 11, 12, 15, 21, 22, 25, 26, 27));
        do_req(1'b0, 1'b1, 16, 2);
        wait_done("left_latency", 4);

        // move_done with no direction: nothing happens.
        do_req(1'b0, 1'b1, 16, 0);
        nreads = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_read) nreads++;
            @(negedge clk);
        end
        chk("none_no_read", 72'(nreads), 72'd0);
        chk("none_window", window, w9(5, 11, 12, 15, 21, 22, 25, 26, 27));
        chk("none_valid", {71'd0, window_valid}, 72'd1);

        // Full load with two wait cycles per read.
        wait_cfg = 2;
        push3(0, 1, 2); push3(10, 11, 12); push3(20, 21, 22);
        exp_win_q.push_back(w9(0, 1, 2, 10, 11, 12, 20, 21, 22));
        do_req(1'b1, 1'b0, 11, 0);
        wait_done("wait_latency", 28);
        wait_cfg = 0;

        // Overrun: move_done during a full fetch is dropped.
        push3(0, 1, 2); push3(10, 11, 12); push3(20, 21, 22);
        exp_win_q.push_back(w9(0, 1, 2, 10, 11, 12, 20, 21, 22));
        do_req(1'b1, 1'b0, 11, 0);
        @(negedge clk);
        direction = 2'd1;
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        direction = 2'd0;
        chk("overrun_set", {71'd0, overrun}, 72'd1);
        wait_done("overrun_latency", 10);
        chk("overrun_sticky", {71'd0, overrun}, 72'd1);

        // Priority: load_initial and move_done together give a full load.
        push3(11, 12, 13); push3(21, 22, 23); push3(31, 32, 33);
        exp_win_q.push_back(w9(11, 12, 13, 21, 22, 23, 31, 32, 33));
        do_req(1'b1, 1'b1, 22, 1);
        chk("priority_overrun_clear", {71'd0, overrun}, 72'd0);
        wait_done("priority_latency", 10);

        // Reset in the middle of a partial fetch.
        push3(14, 24, 34);
        exp_win_q.push_back(w9(12, 13, 14, 22, 23, 24, 32, 33, 34));
        do_req(1'b0, 1'b1, 23, 1);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk("midrst_mem_read", {71'd0, mem_read}, 72'd0);
        chk("midrst_mem_addr", {64'd0, mem_addr}, 72'd0);
        chk("midrst_window", window, 72'd0);
        chk("midrst_valid", {71'd0, window_valid}, 72'd0);
        chk("midrst_done", {71'd0, window_done}, 72'd0);
        exp_addr_q.delete();
        exp_win_q.delete();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        nreads = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_read || window_valid) nreads++;
        end
        chk("post_reset_idle", 72'(nreads), 72'd0);

        // Address wrap: centre 0 with stride 10.
        push3(245, 246, 247); push3(255, 0, 1); push3(9, 10, 11);
        exp_win_q.push_back(w9(245, 246, 247, 255, 0, 1, 9, 10, 11));
        do_req(1'b1, 1'b0, 0, 0);
        chk("wrap_first_addr", {64'd0, mem_addr}, 72'd245);
        wait_done("wrap_latency", 10);

        repeat (2) @(negedge clk);
        chk("queues_empty", 72'(exp_addr_q.size() + exp_win_q.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
